// File: rtl/spi_pkg.sv
// spi_pkg -- definitions shared by the SPI slave receiver and the SPI master.
//   SPI_DATA_W  : default frame length in bits
//   spi_state_e : shift-engine state encoding (IDLE=0, SHIFT=1)
//   spi_cnt_w() : bit-counter width able to hold 0..data_w
package spi_pkg;

  localparam int SPI_DATA_W = 12;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  function automatic int spi_cnt_w(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2 -- two-flop synchronizer for one asynchronous input bit.
//   clk     : destination clock
//   rst     : synchronous active-high reset, loads RST_VAL into both flops
//   d       : asynchronous input
//   q       : synchronized output (two clk cycles of latency)
//   RST_VAL : idle level of the input, so reset release creates no false edge
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx -- SPI mode 0 slave, oversampled in the clk domain.
//   clk       : system clock, all logic on rising edge
//   rst       : synchronous active-high reset
//   sclk      : serial clock from master (async)
//   cs_n      : active-low chip select (async)
//   mosi      : serial data from master (async)
//   miso      : serial data to master, changes after sclk falls
//   tx_data   : word returned to the master, captured at cs_n fall
//   rx_data   : last complete received word
//   rx_valid  : one-cycle pulse when rx_data is updated
//   frame_err : one-cycle pulse when cs_n rises mid-frame
//
// state | meaning
// IDLE  | waiting for cs_n fall; sclk edges ignored, miso holds
// SHIFT | frame active; sample mosi on sclk rise, advance miso on sclk fall
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W    = SPI_DATA_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err
);

  localparam int               CNT_W    = spi_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic w_sclk_s;
  logic w_cs_n_s;
  logic w_mosi_s;

  sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(w_sclk_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst(rst), .d(cs_n), .q(w_cs_n_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(w_mosi_s));

  logic r_sclk_d;
  logic r_cs_n_d;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_fall;
  logic w_cs_rise;

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall   = ~w_cs_n_s & r_cs_n_d;
  assign w_cs_rise   = w_cs_n_s & ~r_cs_n_d;

  spi_state_e       r_state;
  spi_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_tx_sh;
  logic              r_miso;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_frame_err;

  logic w_load;
  logic w_sample;
  logic w_shift_out;
  logic w_done;
  logic w_abort;

  logic [DATA_W-1:0] w_rx_next;
  logic [DATA_W-1:0] w_tx_next;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_W-1];
  endfunction

  assign w_rx_next = LSB_FIRST ? {w_mosi_s, r_rx_sh[DATA_W-1:1]}
                               : {r_rx_sh[DATA_W-2:0], w_mosi_s};
  assign w_tx_next = LSB_FIRST ? (r_tx_sh >> 1) : (r_tx_sh << 1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // The final sample wins over a simultaneous cs_n rise, so a frame whose
  // last edge coincides with deselect still completes. A cs_n rise that
  // coincides with a non-final sample leaves partial data, hence the error.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_sample    = 1'b0;
    w_shift_out = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = SHIFT;
          w_load      = 1'b1;
        end
      end
      SHIFT: begin
        w_sample    = w_sclk_rise;
        w_shift_out = w_sclk_fall;
        if (w_sclk_rise && (r_cnt == LAST_CNT)) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_abort     = (r_cnt != '0) || w_sclk_rise;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_rx_sh is never cleared: a complete frame overwrites all DATA_W bits,
  // so leftovers from an aborted frame cannot reach rx_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_d    <= 1'b0;
      r_cs_n_d    <= 1'b1;
      r_cnt       <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_miso      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sclk_d    <= w_sclk_s;
      r_cs_n_d    <= w_cs_n_s;
      r_rx_valid  <= w_done;
      r_frame_err <= w_abort;
      if (w_load) begin
        r_tx_sh <= tx_data;
        r_miso  <= first_bit(tx_data);
        r_cnt   <= '0;
      end else if (w_shift_out) begin
        r_tx_sh <= w_tx_next;
        r_miso  <= first_bit(w_tx_next);
      end
      if (w_sample) begin
        r_rx_sh <= w_rx_next;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_done) r_rx_data <= w_rx_next;
    end
  end

  assign miso      = r_miso;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx -- bench for spi_slave_rx. A bench-side SPI master drives
// two slaves (LSB-first and MSB-first) sharing sclk/cs_n/mosi; a scoreboard
// of expected words and frame-error pulses is checked every clk cycle.
module tb_spi_slave_rx;
  import spi_pkg::*;

  localparam int DW  = SPI_DATA_W;
  localparam int H   = 6;
  localparam int GAP = 6;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic [DW-1:0] tx_data = '0;

  logic miso_l, miso_m;
  logic rx_valid_l, rx_valid_m;
  logic frame_err_l, frame_err_m;
  logic [DW-1:0] rx_data_l, rx_data_m;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_l[$];
  logic [DW-1:0] exp_m[$];
  int ferr_pend_l = 0;
  int ferr_pend_m = 0;
  logic [DW-1:0] model_l = '0;
  logic [DW-1:0] model_m = '0;
  int n_valid_l = 0;
  int n_ferr_l  = 0;
  logic hold_chk = 1'b0;
  logic hold_exp = 1'b0;
  logic rst_seen = 1'b0;
  logic [DW-1:0] sent = '0;
  logic [DW-1:0] dout = '0;

  spi_slave_rx #(.DATA_W(DW), .LSB_FIRST(1'b1)) u_dut_l (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_l), .tx_data(tx_data), .rx_data(rx_data_l),
    .rx_valid(rx_valid_l), .frame_err(frame_err_l)
  );

  spi_slave_rx #(.DATA_W(DW), .LSB_FIRST(1'b0)) u_dut_m (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_m), .tx_data(tx_data), .rx_data(rx_data_m),
    .rx_valid(rx_valid_m), .frame_err(frame_err_m)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_seen <= rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word seen by an MSB-first receiver when bits arrive in time order v[0], v[1], ...
  function automatic logic [DW-1:0] rev(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_seen) begin
      exp_l.delete();
      exp_m.delete();
      ferr_pend_l = 0;
      ferr_pend_m = 0;
      model_l     = '0;
      model_m     = '0;
      chk("rst_rx_valid", {30'b0, rx_valid_l, rx_valid_m}, 0);
      chk("rst_frame_err", {30'b0, frame_err_l, frame_err_m}, 0);
      chk("rst_rx_data_l", rx_data_l, 0);
      chk("rst_rx_data_m", rx_data_m, 0);
      chk("rst_miso", {30'b0, miso_l, miso_m}, 0);
    end else begin
      chk("spurious_valid_l", (exp_l.size() == 0) ? rx_valid_l : 1'b0, 0);
      chk("spurious_valid_m", (exp_m.size() == 0) ? rx_valid_m : 1'b0, 0);
      if (rx_valid_l) begin
        n_valid_l++;
        if (exp_l.size() != 0) model_l = exp_l.pop_front();
      end
      if (rx_valid_m && exp_m.size() != 0) model_m = exp_m.pop_front();
      chk("rx_data_l", rx_data_l, model_l);
      chk("rx_data_m", rx_data_m, model_m);
      chk("spurious_ferr_l", (ferr_pend_l == 0) ? frame_err_l : 1'b0, 0);
      chk("spurious_ferr_m", (ferr_pend_m == 0) ? frame_err_m : 1'b0, 0);
      if (frame_err_l) begin
        n_ferr_l++;
        if (ferr_pend_l > 0) ferr_pend_l--;
      end
      if (frame_err_m && ferr_pend_m > 0) ferr_pend_m--;
      if (hold_chk) chk("miso_hold", miso_l, hold_exp);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [DW-1:0] din, input int nbits);
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi    = din[i];
      sent[i] = din[i];
      clks(H);
      dout[i] = miso_l;
      sclk    = 1'b1;
      if (i == DW-1) begin
        exp_l.push_back(sent);
        exp_m.push_back(rev(sent));
      end
      clks(H);
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame(input int nbits);
    clks(H);
    if (nbits > 0 && nbits < DW) begin
      ferr_pend_l++;
      ferr_pend_m++;
    end
    cs_n = 1'b1;
    clks(GAP);
  endtask

  task automatic full_frame(input logic [DW-1:0] din);
    send_bits(din, DW);
    end_frame(DW);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      mosi = 1'(i);
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
      clks(H);
    end
  endtask

  task automatic drain();
    int budget = 200;
    while ((exp_l.size() + exp_m.size() + ferr_pend_l + ferr_pend_m) != 0 && budget > 0) begin
      clks(1);
      budget--;
    end
    chk("drain_pending", exp_l.size() + exp_m.size() + ferr_pend_l + ferr_pend_m, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] din;
    int v0, f0;

    clks(4);
    rst = 1'b0;
    clks(3);
    chk("reset_rx_data", rx_data_l, 0);
    chk("reset_miso", miso_l, 0);
    chk("reset_pulses", {30'b0, rx_valid_l, frame_err_l}, 0);

    // master din A5C, slave returns 3F1
    v0 = n_valid_l;
    tx_data = 12'h3F1;
    full_frame(12'hA5C);
    drain();
    chk("basic_rx_data", rx_data_l, 12'hA5C);
    chk("basic_dout", dout, 12'h3F1);
    chk("basic_valid_count", n_valid_l - v0, 1);

    // back-to-back random frames
    v0 = n_valid_l;
    for (int k = 0; k < 10; k++) begin
      din     = DW'($urandom);
      tx_data = DW'($urandom);
      full_frame(din);
      chk("rand_rx_data", rx_data_l, din);
      chk("rand_dout", dout, tx_data);
    end
    drain();
    chk("rand_valid_count", n_valid_l - v0, 10);

    // cs_n raised after 5 sclk rises
    v0 = n_valid_l;
    f0 = n_ferr_l;
    tx_data = '0;
    send_bits(12'h7FE, 5);
    end_frame(5);
    drain();
    chk("abort_ferr_count", n_ferr_l - f0, 1);
    chk("abort_valid_count", n_valid_l - v0, 0);
    chk("abort_rx_unchanged", rx_data_l, din);
    full_frame(12'h001);
    drain();
    chk("after_abort_rx", rx_data_l, 12'h001);

    // reset after 7 bits of FFF
    v0 = n_valid_l;
    f0 = n_ferr_l;
    send_bits(12'hFFF, 7);
    rst  = 1'b1;
    cs_n = 1'b1;
    mosi = 1'b0;
    clks(5);
    rst = 1'b0;
    clks(4);
    chk("midrst_rx_data_l", rx_data_l, 0);
    chk("midrst_rx_data_m", rx_data_m, 0);
    chk("midrst_miso", miso_l, 0);
    chk("midrst_valid_count", n_valid_l - v0, 0);
    chk("midrst_ferr_count", n_ferr_l - f0, 0);
    full_frame(12'h800);
    drain();
    chk("after_rst_rx", rx_data_l, 12'h800);

    // first bit 1 then zeros: MSB-first slave sees 800
    full_frame(12'h001);
    drain();
    chk("msb_first_rx", rx_data_m, 12'h800);
    chk("lsb_first_rx", rx_data_l, 12'h001);

    // cs_n rise coincides with the final sclk rise
    v0 = n_valid_l;
    f0 = n_ferr_l;
    tx_data = 12'h0C3;
    din     = 12'h5A3;
    send_bits(din, DW-1);
    mosi         = din[DW-1];
    sent[DW-1]   = din[DW-1];
    clks(H);
    dout[DW-1] = miso_l;
    sclk = 1'b1;
    cs_n = 1'b1;
    exp_l.push_back(sent);
    exp_m.push_back(rev(sent));
    clks(H);
    sclk = 1'b0;
    clks(GAP);
    drain();
    chk("coinc_rx", rx_data_l, 12'h5A3);
    chk("coinc_valid_count", n_valid_l - v0, 1);
    chk("coinc_ferr_count", n_ferr_l - f0, 0);
    chk("coinc_dout", dout, 12'h0C3);

    // sclk after completion with cs_n low, then 20 pulses with cs_n high
    v0 = n_valid_l;
    f0 = n_ferr_l;
    tx_data = 12'h800;
    send_bits(12'h123, DW);
    hold_exp = 1'b1;
    hold_chk = 1'b1;
    pulses(3);
    cs_n = 1'b1;
    clks(GAP);
    pulses(20);
    chk("idle_miso_final", miso_l, 1);
    hold_chk = 1'b0;
    drain();
    chk("idle_rx", rx_data_l, 12'h123);
    chk("idle_valid_count", n_valid_l - v0, 1);
    chk("idle_ferr_count", n_ferr_l - f0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 12, frame length in bits.
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = bit 0 shifted first, 0 = MSB first.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port sclk, input, 1, serial clock from master, asynchronous to clk.
REQ-006 SHALL have port cs_n, input, 1, chip select, active-low, asynchronous.
REQ-007 SHALL have port mosi, input, 1, serial data from master, asynchronous.
REQ-008 SHALL have port miso, output, 1, serial data to master.
REQ-009 SHALL have port tx_data, input, DATA_W, word returned to master in next frame.
REQ-010 SHALL have port rx_data, output, DATA_W, last complete received word.
REQ-011 SHALL have port rx_valid, output, 1, one-cycle pulse: rx_data updated.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse: cs_n deasserted mid-frame.

Function
REQ-013 SHALL pass sclk, cs_n and mosi each through a 2-flop synchronizer before use; no raw input reaches any other logic.
REQ-014 SHALL detect sclk rise/fall and cs_n fall/rise by comparing synchronized value with its 1-cycle-delayed copy.
REQ-015 SHALL implement SPI mode 0: sample mosi on sclk rise, update miso on sclk fall.
REQ-016 SHALL use states IDLE, SHIFT; IDLE->SHIFT on cs_n fall; SHIFT->IDLE on cs_n rise or after the DATA_W-th sample.
REQ-017 On cs_n fall, SHALL load tx_data into the transmit shift register, clear the bit counter, and drive miso with the first tx bit in the same cycle the state becomes SHIFT.
REQ-018 In SHIFT, each sclk rise SHALL shift synchronized mosi into the receive register in the LSB_FIRST order and increment the bit counter (width clog2(DATA_W)+1).
REQ-019 On the DATA_W-th sclk rise, SHALL write the assembled word to rx_data and pulse rx_valid for exactly one clk cycle, in the cycle after the edge-detect cycle (3 clk edges after raw sclk is first sampled high).
REQ-020 rx_data SHALL hold its value until the next complete frame; partial frames never modify it.
REQ-021 cs_n rise in SHIFT with counter in 1..DATA_W-1 SHALL pulse frame_err one cycle, discard partial data, return to IDLE.
REQ-022 cs_n rise with counter 0 SHALL return to IDLE with no pulse.
REQ-023 sclk edges while in IDLE, or after the frame completes with cs_n still low, SHALL be ignored; miso SHALL hold its last value.
REQ-024 cs_n rise and DATA_W-th sclk rise detected in the same cycle SHALL count as a complete frame: rx_valid pulses, frame_err does not.
REQ-025 Correct operation requires sclk high and low phases each >= 4 clk cycles; the block need not detect violations.

Reset
REQ-026 While rst is high at a clk edge: state IDLE, rx_data 0, rx_valid 0, frame_err 0, miso 0, counter 0, synchronizers loaded with idle levels (sclk 0, cs_n 1, mosi 0).
REQ-027 Reset mid-frame SHALL abandon the frame without rx_valid or frame_err; the next cs_n fall after release starts a fresh frame.

Structure
REQ-028 DATA_W default and the state encoding (IDLE=0, SHIFT=1) SHALL live in shared package spi_pkg, also used by the spi master.
REQ-029 The 2-flop synchronizer SHALL be a sub-module sync2 (clk, rst, d, q, reset value parameter), instantiated three times.

Verification
REQ-030 Bench SHALL cover: spi master (din=12'hA5C) driving this block, tx_data=12'h3F1 -> rx_valid once, rx_data=12'hA5C, master dout=12'h3F1.
REQ-031 Bench SHALL cover: 10 back-to-back random frames from the master -> 10 rx_valid pulses, each rx_data equal to the corresponding din.
REQ-032 Bench SHALL cover: cs_n raised after 5 sclk rises -> one frame_err pulse, no rx_valid, rx_data unchanged; next frame 12'h001 received correctly.
REQ-033 Bench SHALL cover: rst pulsed after 7 bits of frame 12'hFFF -> all outputs 0, no pulses; following frame 12'h800 yields rx_data=12'h800.
REQ-034 Bench SHALL cover: LSB_FIRST=0, mosi bits 1,0,0,...,0 -> rx_data=12'h800.
REQ-035 Bench SHALL cover: 20 extra sclk pulses with cs_n high -> no rx_valid, no frame_err, miso constant.
